// File: rtl/ex_muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit beside the EX-stage ALU; owns HI/LO.
// Latency: accept edge + 32 iteration edges + 1 sign-fix edge (busy for 33 cycles).
// Backpressure: stall is raised while busy whenever EX presents start, MFHI/MFLO or MTHI/MTLO.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start, op, opA, opB      mult/div issue with forwarded operands (sampled at accept only)
//   mf_req, mf_sel, mf_data  MFHI/MFLO read port (mf_data is combinational)
//   mt_we, mt_sel, mt_data   MTHI/MTLO write port
//   busy, stall              operation in flight / freeze IF-ID-EX
//   hi, lo                   architectural HI/LO registers
//   div_by_zero              one-cycle pulse when a divide by zero is issued
module ex_muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             mf_req,
  input  logic             mf_sel,
  input  logic             mt_we,
  input  logic             mt_sel,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] work;    // multiply: product accumulator; divide: {rem, quot}
  logic [WIDTH-1:0]   a_mag;   // multiplicand magnitude
  logic [WIDTH-1:0]   b_mag;   // multiplier (shifted right each step) or divisor
  logic               is_div;
  logic               neg_q;   // product / quotient needs negation
  logic               neg_r;   // remainder needs negation
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               dbz_q;

  // Operand decode at accept. op[1]=divide, op[0]=unsigned.
  logic             op_div;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign op_div = op[1];
  assign sign_a = ~op[0] & opA[WIDTH-1];
  assign sign_b = ~op[0] & opB[WIDTH-1];
  assign abs_a  = sign_a ? -opA : opA;
  assign abs_b  = sign_b ? -opB : opB;

  // Shift-add multiply step: add into the upper half, then shift right with the carry.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, (b_mag[0] ? a_mag : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, work[WIDTH-1:1]};

  // Restoring divide step. The shifted remainder needs WIDTH+1 bits; the difference
  // always fits in WIDTH bits when it is kept because it is then below the divisor.
  logic [WIDTH:0]     div_top;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  assign div_top  = work[2*WIDTH-1:WIDTH-1];
  assign div_ok   = (div_top >= {1'b0, b_mag});
  assign div_rem  = div_top[WIDTH-1:0] - b_mag;
  assign div_next = div_ok ? {div_rem, work[WIDTH-2:0], 1'b1}
                           : {div_top[WIDTH-1:0], work[WIDTH-2:0], 1'b0};

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = neg_q ? -work : work;
  assign quot_fix = neg_q ? -work[WIDTH-1:0] : work[WIDTH-1:0];
  assign rem_fix  = neg_r ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      work   <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      dbz_q  <= 1'b0;
    end else begin
      dbz_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op_div && (opB == '0)) begin
              dbz_q <= 1'b1;
            end else begin
              a_mag  <= abs_a;
              b_mag  <= abs_b;
              is_div <= op_div;
              neg_q  <= sign_a ^ sign_b;
              neg_r  <= sign_a;
              // Divide keeps the dividend in the low half so it shifts into the remainder.
              work   <= op_div ? {{WIDTH{1'b0}}, abs_a} : '0;
              cnt    <= '0;
              state  <= S_RUN;
            end
          end else if (mt_we) begin
            if (mt_sel) hi_q <= mt_data;
            else        lo_q <= mt_data;
          end
        end
        S_RUN: begin
          if (is_div) begin
            work <= div_next;
          end else begin
            work  <= mul_next;
            b_mag <= b_mag >> 1;
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) state <= S_FIX;
        end
        S_FIX: begin
          if (is_div) begin
            lo_q <= quot_fix;
            hi_q <= rem_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state != S_IDLE);
  assign stall       = busy & (start | mf_req | mt_we);
  assign mf_data     = mf_sel ? hi_q : lo_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
